// File: rtl/qflop_pkg.sv
// Shared types and four-phase level constants for the Q-Flop fork initiator.
package qflop_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        REQ_HI = 3'd2,
        REQ_LO = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic REQ_ASSERT = 1'b1;
    localparam logic REQ_IDLE   = 1'b0;

endpackage

// File: rtl/qflop_sync_bit.sv
// Multi-flop synchronizer for one asynchronous branch ack.
module qflop_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/qflop_fork_tx.sv
// Clocked four-phase bundled-data initiator forking one request to N_BRANCH Q-Flop branches,
// joining their acks with C-element semantics (all risen, then all fallen).
//
// state  | meaning
// IDLE   | waiting for a word; in_ready=1
// SETUP  | data_out stable, counting setup cycles, waiting for all enabled acks low
// REQ_HI | req_out=1, waiting for every enabled ack high
// REQ_LO | req_out=0, waiting for every enabled ack low
// ERR    | an ack phase timed out; waits for clr_err
import qflop_pkg::*;

module qflop_fork_tx #(
    parameter int WIDTH       = 8,
    parameter int N_BRANCH    = 5,
    parameter int SYNC_STAGES = 2,
    parameter int SETUP_CYC   = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [N_BRANCH-1:0] ack_mask,
    output logic                req_out,
    output logic [WIDTH-1:0]    data_out,
    input  logic [N_BRANCH-1:0] ack_in,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    input  logic                clr_err
);

    localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] TMR_LOAD   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                state;
    logic [N_BRANCH-1:0]   ack_s;
    logic [N_BRANCH-1:0]   mask_q;
    logic [SW-1:0]         setup_cnt;
    logic [TW-1:0]         tmr;
    logic                  all_hi;
    logic                  all_lo;
    logic                  timer_hit;

    for (genvar i = 0; i < N_BRANCH; i++) begin : g_sync
        qflop_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (ack_in[i]),
            .q     (ack_s[i])
        );
    end

    // Masked-out branches count as both high and low, so an empty mask completes on its own.
    assign all_hi    = &(ack_s | ~mask_q);
    assign all_lo    = ~|(ack_s & mask_q);
    assign timer_hit = (TIMEOUT != 0) && (tmr == '0);

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_out     <= REQ_IDLE;
            data_out    <= '0;
            mask_q      <= '0;
            setup_cnt   <= '0;
            tmr         <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_out  <= in_data;
                        mask_q    <= ack_mask;
                        setup_cnt <= SETUP_LOAD;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt != '0) begin
                        setup_cnt <= setup_cnt - 1'b1;
                    end else if (all_lo) begin
                        req_out <= REQ_ASSERT;
                        tmr     <= TMR_LOAD;
                        state   <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (all_hi) begin
                        req_out <= REQ_IDLE;
                        tmr     <= TMR_LOAD;
                        state   <= REQ_LO;
                    end else if (timer_hit) begin
                        req_out     <= REQ_IDLE;
                        timeout_err <= 1'b1;
                        state       <= ERR;
                    end else if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end
                end
                REQ_LO: begin
                    if (all_lo) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (timer_hit) begin
                        timeout_err <= 1'b1;
                        state       <= ERR;
                    end else if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ERR: begin
                    if (clr_err) begin
                        timeout_err <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qflop_fork_tx.sv
// Directed bench for qflop_fork_tx: instance a uses TIMEOUT=255, instance b uses TIMEOUT=8.
module tb_qflop_fork_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       a_valid, a_ready, a_req, a_busy, a_done, a_terr, a_clr;
    logic [7:0] a_data, a_dout;
    logic [4:0] a_mask, a_ack;
    logic       b_valid, b_ready, b_req, b_busy, b_done, b_terr, b_clr;
    logic [7:0] b_data, b_dout;
    logic [4:0] b_mask, b_ack;

    qflop_fork_tx #(.WIDTH(8), .N_BRANCH(5), .SYNC_STAGES(2), .SETUP_CYC(1), .TIMEOUT(255)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .ack_mask(a_mask), .req_out(a_req), .data_out(a_dout), .ack_in(a_ack), .busy(a_busy),
        .done(a_done), .timeout_err(a_terr), .clr_err(a_clr)
    );

    qflop_fork_tx #(.WIDTH(8), .N_BRANCH(5), .SYNC_STAGES(2), .SETUP_CYC(1), .TIMEOUT(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .ack_mask(b_mask), .req_out(b_req), .data_out(b_dout), .ack_in(b_ack), .busy(b_busy),
        .done(b_done), .timeout_err(b_terr), .clr_err(b_clr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_a(input logic [7:0] d, input logic [4:0] m);
        a_valid = 1'b1;
        a_data  = d;
        a_mask  = m;
        tick();
        a_valid = 1'b0;
    endtask

    logic [7:0] words [3];
    logic [7:0] prev_dout;
    logic       prev_req;
    bit         acc;
    int         wi, di, ri, seen_done, seen_low;

    initial begin
        words = '{8'h01, 8'h02, 8'h03};
        rst_n = 1'b0;
        a_valid = 0; a_data = 0; a_mask = 0; a_ack = 0; a_clr = 0;
        b_valid = 0; b_data = 0; b_mask = 0; b_ack = 0; b_clr = 0;

        // reset values
        #2;
        check("rst_req", a_req, 1'b0);
        check("rst_dout", a_dout, 8'h00);
        check("rst_ready", a_ready, 1'b1);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_terr", a_terr, 1'b0);
        #10 rst_n = 1'b1;
        tick();

        // nominal cycle, acks raised then dropped one by one
        accept_a(8'hA5, 5'b11111);
        check("nom_setup_dout", a_dout, 8'hA5);
        check("nom_setup_req", a_req, 1'b0);
        check("nom_setup_ready", a_ready, 1'b0);
        check("nom_setup_busy", a_busy, 1'b1);
        tick();
        check("nom_req_rise", a_req, 1'b1);
        for (int i = 0; i < 5; i++) begin
            a_ack[i] = 1'b1;
            tick(); tick();
            check("nom_req_held", a_req, 1'b1);
        end
        tick();
        check("nom_req_fall", a_req, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a_ack[i] = 1'b0;
            tick(); tick();
            check("nom_no_early_done", a_done, 1'b0);
            check("nom_dout_held", a_dout, 8'hA5);
        end
        tick();
        check("nom_done", a_done, 1'b1);
        check("nom_done_dout", a_dout, 8'hA5);
        tick();
        check("nom_done_pulse", a_done, 1'b0);
        check("nom_ready_back", a_ready, 1'b1);

        // partial acks hold the request
        accept_a(8'h3C, 5'b11111);
        tick();
        a_ack = 5'b01111;
        seen_done = 0;
        seen_low  = 0;
        repeat (100) begin
            tick();
            if (a_done) seen_done++;
            if (!a_req) seen_low++;
        end
        check("part_req_low_cycles", seen_low, 0);
        check("part_done_count", seen_done, 0);
        check("part_terr", a_terr, 1'b0);
        a_ack = 5'b11111;
        repeat (3) tick();
        check("part_req_fall", a_req, 1'b0);
        a_ack = 5'b00000;
        repeat (3) tick();
        check("part_done", a_done, 1'b1);

        // empty mask completes without any ack
        accept_a(8'h99, 5'b00000);
        tick();
        check("m0_req_rise", a_req, 1'b1);
        tick();
        check("m0_req_fall", a_req, 1'b0);
        check("m0_no_done", a_done, 1'b0);
        tick();
        check("m0_done", a_done, 1'b1);

        // mask 00101: only a and c matter
        accept_a(8'h77, 5'b00101);
        tick();
        check("mask_req_rise", a_req, 1'b1);
        a_ack = 5'b00101;
        tick(); tick();
        check("mask_req_held", a_req, 1'b1);
        tick();
        check("mask_req_fall", a_req, 1'b0);
        a_ack = 5'b00000;
        repeat (3) tick();
        check("mask_done", a_done, 1'b1);

        // stale high ack b blocks the request
        a_ack = 5'b00010;
        repeat (3) tick();
        accept_a(8'h5A, 5'b11111);
        repeat (6) tick();
        check("stale_req_blocked", a_req, 1'b0);
        check("stale_busy", a_busy, 1'b1);
        a_ack = 5'b00000;
        tick(); tick();
        check("stale_req_still_low", a_req, 1'b0);
        tick();
        check("stale_req_rise", a_req, 1'b1);
        a_ack = 5'b11111;
        repeat (3) tick();
        check("stale_req_fall", a_req, 1'b0);
        a_ack = 5'b00000;
        repeat (3) tick();
        check("stale_done", a_done, 1'b1);
        check("stale_dout", a_dout, 8'h5A);

        // timeout on instance b
        b_valid = 1'b1; b_data = 8'hC3; b_mask = 5'b11111;
        tick();
        b_valid = 1'b0;
        tick();
        check("to_req_rise", b_req, 1'b1);
        b_ack = 5'b00001;
        repeat (7) tick();
        check("to_req_before", b_req, 1'b1);
        check("to_terr_before", b_terr, 1'b0);
        tick();
        check("to_terr", b_terr, 1'b1);
        check("to_req_drop", b_req, 1'b0);
        check("to_ready", b_ready, 1'b0);
        check("to_busy", b_busy, 1'b1);
        check("to_dout", b_dout, 8'hC3);
        b_ack = 5'b00000;
        repeat (5) tick();
        check("to_ready_stuck", b_ready, 1'b0);
        check("to_terr_sticky", b_terr, 1'b1);
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        check("to_clr_ready", b_ready, 1'b1);
        check("to_clr_terr", b_terr, 1'b0);

        // back-to-back words with in_valid held, branches follow req
        wi = 0; di = 0; ri = 0;
        a_valid = 1'b1; a_data = words[0]; a_mask = 5'b11111;
        prev_req  = a_req;
        prev_dout = a_dout;
        for (int cyc = 0; cyc < 100 && di < 3; cyc++) begin
            acc = a_valid && a_ready;
            tick();
            if (acc) begin
                wi++;
                if (wi < 3) a_data = words[wi];
                else a_valid = 1'b0;
            end
            a_ack = a_req ? 5'b11111 : 5'b00000;
            if (a_req && !prev_req) begin
                check("b2b_setup_stable", a_dout, prev_dout);
                if (ri < 3) check("b2b_req_word", a_dout, words[ri]);
                ri++;
            end
            if (a_done) begin
                if (di < 3) check("b2b_done_word", a_dout, words[di]);
                di++;
            end
            prev_req  = a_req;
            prev_dout = a_dout;
        end
        check("b2b_done_count", di, 3);
        check("b2b_req_count", ri, 3);
        a_valid = 1'b0;
        a_ack   = 5'b00000;
        repeat (4) tick();

        // asynchronous reset while the request is high
        accept_a(8'hE7, 5'b11111);
        tick();
        check("arst_req_before", a_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", a_req, 1'b0);
        check("arst_dout", a_dout, 8'h00);
        check("arst_ready", a_ready, 1'b1);
        #3 rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
